// File: rtl/psk_symbol_mapper_pkg.sv
// Shared constants for the PSK transmit mapper and its constellation lookup.
// Mode and state encodings live here so the pilot/preamble generators agree.
package psk_symbol_mapper_pkg;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Lookup selector: latched mode plus the two MSBs of the shift register
    typedef struct packed {
        logic       mode;
        logic [1:0] bits;
    } lut_sel_t;

    function automatic logic [1:0] bits_per_sym(input logic m);
        return (m == MODE_QPSK) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/psk_point_lut.sv
// Combinational constellation lookup: maps {mode, sr[7:6]} to a signed I/Q point.
// A set bit gives -AMP, a clear bit gives +AMP, matching the detector's sign decisions.
module psk_point_lut
    import psk_symbol_mapper_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMP   = 8192
) (
    input  lut_sel_t                i_sel,
    output logic signed [WIDTH-1:0] o_i,
    output logic signed [WIDTH-1:0] o_q
);

    localparam logic signed [WIDTH-1:0] POS = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] NEG = -POS;

    logic w_q_bit;

    // BPSK puts the same bit on both rails so the detector sees sign(I+Q)
    assign w_q_bit = (i_sel.mode == MODE_QPSK) ? i_sel.bits[0] : i_sel.bits[1];

    always_comb begin
        o_i = i_sel.bits[1] ? NEG : POS;
        o_q = w_q_bit       ? NEG : POS;
    end

endmodule

// File: rtl/psk_symbol_mapper.sv
// Byte-stream to BPSK/QPSK symbol mapper: serialises bytes MSB-first and holds
// each constellation point for SPS enabled cycles, with back-to-back byte reload.
module psk_symbol_mapper
    import psk_symbol_mapper_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMP   = 8192,
    parameter int SPS   = 8
) (
    input  logic                    clk,
    input  logic                    rst_32M768,
    input  logic                    clk_enable,
    input  logic                    mode,
    input  logic [7:0]              s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic signed [WIDTH-1:0] I_tdata,
    output logic                    I_tvalid,
    output logic signed [WIDTH-1:0] Q_tdata,
    output logic                    Q_tvalid,
    output logic                    sym_strobe,
    output logic                    busy
);

    localparam int              SMP_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SPS - 1);

    logic [0:0]              r_state;
    logic [7:0]              r_sr;
    logic                    r_m;
    logic [2:0]              r_sym;
    logic [SMP_W-1:0]        r_smp;
    logic signed [WIDTH-1:0] r_i;
    logic signed [WIDTH-1:0] r_q;
    logic                    r_vld;
    logic                    r_strobe;

    logic                    w_last_smp;
    logic                    w_last_sym;
    logic                    w_accept;
    lut_sel_t                w_sel;
    logic signed [WIDTH-1:0] w_pt_i;
    logic signed [WIDTH-1:0] w_pt_q;

    assign w_last_smp = (r_smp == SMP_LAST);
    assign w_last_sym = (r_m == MODE_QPSK) ? (r_sym == 3'd3) : (r_sym == 3'd7);
    assign s_tready   = clk_enable &
                        ((r_state == ST_IDLE) | ((r_state == ST_RUN) & w_last_sym & w_last_smp));
    assign w_accept   = s_tvalid & s_tready;
    assign w_sel      = {r_m, r_sr[7:6]};

    psk_point_lut #(
        .WIDTH (WIDTH),
        .AMP   (AMP)
    ) u_lut (
        .i_sel (w_sel),
        .o_i   (w_pt_i),
        .o_q   (w_pt_q)
    );

    always_ff @(posedge clk) begin
        if (rst_32M768) begin
            r_state  <= ST_IDLE;
            r_sr     <= 8'd0;
            r_m      <= MODE_BPSK;
            r_sym    <= 3'd0;
            r_smp    <= '0;
            r_i      <= '0;
            r_q      <= '0;
            r_vld    <= 1'b0;
            r_strobe <= 1'b0;
        end else if (clk_enable) begin
            // Control path: accept reloads everything, otherwise step through the byte
            if (w_accept) begin
                r_state <= ST_RUN;
                r_sr    <= s_tdata;
                r_m     <= mode;
                r_sym   <= 3'd0;
                r_smp   <= '0;
            end else if (r_state == ST_RUN) begin
                if (w_last_smp) begin
                    r_smp <= '0;
                    if (w_last_sym) begin
                        r_state <= ST_IDLE;
                        r_sym   <= 3'd0;
                    end else begin
                        r_sym <= r_sym + 3'd1;
                        r_sr  <= r_sr << bits_per_sym(r_m);
                    end
                end else begin
                    r_smp <= r_smp + 1'b1;
                end
            end

            // Output path reflects the symbol held before this edge's reload
            if (r_state == ST_RUN) begin
                r_i      <= w_pt_i;
                r_q      <= w_pt_q;
                r_vld    <= 1'b1;
                r_strobe <= (r_smp == '0);
            end else begin
                r_i      <= '0;
                r_q      <= '0;
                r_vld    <= 1'b0;
                r_strobe <= 1'b0;
            end
        end
    end

    assign I_tdata    = r_i;
    assign Q_tdata    = r_q;
    assign I_tvalid   = r_vld;
    assign Q_tvalid   = r_vld;
    assign sym_strobe = r_strobe;
    assign busy       = (r_state == ST_RUN);

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Randomised scoreboard bench for psk_symbol_mapper: one instance at SPS=4 and one
// at SPS=1, each with its own driver and monitor sharing a single clock.
module tb_psk_symbol_mapper;

    localparam int WIDTH = 16;
    localparam int AMP   = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst        [2];
    logic                    en         [2];
    logic                    mode       [2];
    logic [7:0]              s_tdata    [2];
    logic                    s_tvalid   [2];
    logic                    s_tready   [2];
    logic signed [WIDTH-1:0] I_tdata    [2];
    logic signed [WIDTH-1:0] Q_tdata    [2];
    logic                    I_tvalid   [2];
    logic                    Q_tvalid   [2];
    logic                    sym_strobe [2];
    logic                    busy       [2];

    typedef struct {
        int i;
        int q;
        bit stb;
    } exp_t;

    exp_t q_exp [2][$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_mode [2];
    int   en_ph   [2];

    task automatic check(string nm, int d, logic signed [31:0] act, logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    function automatic int sps_of(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Reference model: expand a byte into its per-cycle (I, Q, strobe) samples
    task automatic push_byte(int d, logic [7:0] b, bit m);
        int   nsym;
        int   ib;
        int   qb;
        exp_t e;
        nsym = m ? 4 : 8;
        for (int s = 0; s < nsym; s++) begin
            ib = m ? int'(b[7 - 2*s]) : int'(b[7 - s]);
            qb = m ? int'(b[6 - 2*s]) : int'(b[7 - s]);
            for (int k = 0; k < sps_of(d); k++) begin
                e.i   = (ib != 0) ? -AMP : AMP;
                e.q   = (qb != 0) ? -AMP : AMP;
                e.stb = (k == 0);
                q_exp[d].push_back(e);
            end
        end
    endtask

    function automatic bit next_en(int d);
        case (en_mode[d])
            0:       return 1'b1;
            1: begin
                en_ph[d] ^= 1;
                return en_ph[d][0];
            end
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // One clock of stimulus; entered and left on a falling edge
    task automatic cycle(int d, bit vld, logic [7:0] data, bit md, output bit acc);
        bit e;
        e           = next_en(d);
        en[d]       = e;
        s_tvalid[d] = vld;
        s_tdata[d]  = data;
        mode[d]     = md;
        #1;
        // Ready only when idle or when the coming edge emits the final sample
        check("s_tready", d, s_tready[d], (e && q_exp[d].size() <= 1));
        acc = vld && (s_tready[d] === 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
            push_byte(d, data, md);
            $display("[TB] dut%0d accepted byte %02h mode %0d", d, data, md);
        end
        check("busy", d, busy[d], (q_exp[d].size() != 0));
    endtask

    task automatic send_byte(int d, logic [7:0] b, bit m, output int tries);
        bit acc;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            cycle(d, 1'b1, b, m, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", d, 0, 1);
    endtask

    task automatic idle(int d, int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(d, 1'b0, 8'($urandom), 1'($urandom), acc);
    endtask

    task automatic drain(int d);
        int guard;
        guard = 0;
        while (q_exp[d].size() != 0 && guard < 600) begin
            idle(d, 1);
            guard++;
        end
        if (q_exp[d].size() != 0) check("drain_timeout", d, q_exp[d].size(), 0);
        idle(d, 2);
    endtask

    task automatic do_reset(int d);
        rst[d]      = 1'b1;
        en[d]       = 1'b0;
        s_tvalid[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q_exp[d].delete();
        rst[d] = 1'b0;
    endtask

    task automatic run(int d);
        int t;
        en_mode[d] = 0;
        send_byte(d, 8'hA5, 1'b0, t);
        drain(d);
        send_byte(d, 8'h1B, 1'b1, t);
        drain(d);
        // Back-to-back QPSK bytes with s_tvalid held high
        send_byte(d, 8'($urandom), 1'b1, t);
        send_byte(d, 8'($urandom), 1'b1, t);
        drain(d);
        en_mode[d] = 1;
        send_byte(d, 8'($urandom), 1'b0, t);
        drain(d);
        // Reset in the middle of symbol 3, then accept on the first enabled cycle
        en_mode[d] = 0;
        send_byte(d, 8'($urandom), 1'b0, t);
        idle(d, 3 * sps_of(d) + 1);
        do_reset(d);
        send_byte(d, 8'h3C, 1'($urandom), t);
        check("accept_after_reset", d, t, 1);
        drain(d);
        send_byte(d, 8'($urandom), 1'b1, t);
        send_byte(d, 8'($urandom), 1'b0, t);
        drain(d);
        en_mode[d] = 2;
        repeat (30) begin
            if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 3));
            send_byte(d, 8'($urandom), 1'($urandom), t);
        end
        drain(d);
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            psk_symbol_mapper #(
                .WIDTH (WIDTH),
                .AMP   (AMP),
                .SPS   ((gi == 0) ? 4 : 1)
            ) u_dut (
                .clk        (clk),
                .rst_32M768 (rst[gi]),
                .clk_enable (en[gi]),
                .mode       (mode[gi]),
                .s_tdata    (s_tdata[gi]),
                .s_tvalid   (s_tvalid[gi]),
                .s_tready   (s_tready[gi]),
                .I_tdata    (I_tdata[gi]),
                .I_tvalid   (I_tvalid[gi]),
                .Q_tdata    (Q_tdata[gi]),
                .Q_tvalid   (Q_tvalid[gi]),
                .sym_strobe (sym_strobe[gi]),
                .busy       (busy[gi])
            );

            // Monitor: after every enabled edge pop one expected sample or expect silence
            always begin : mon
                exp_t e;
                logic ens;
                logic rss;
                @(posedge clk);
                ens = en[gi];
                rss = rst[gi];
                #1;
                if (rss === 1'b1) begin
                    check("rst_I", gi, I_tdata[gi], 0);
                    check("rst_Q", gi, Q_tdata[gi], 0);
                    check("rst_valid", gi, I_tvalid[gi], 0);
                    check("rst_strobe", gi, sym_strobe[gi], 0);
                    check("rst_busy", gi, busy[gi], 0);
                end else if (ens === 1'b1) begin
                    if (q_exp[gi].size() != 0) begin
                        e = q_exp[gi].pop_front();
                        check("I_tvalid", gi, I_tvalid[gi], 1);
                        check("Q_tvalid", gi, Q_tvalid[gi], 1);
                        check("I_tdata", gi, I_tdata[gi], e.i);
                        check("Q_tdata", gi, Q_tdata[gi], e.q);
                        check("sym_strobe", gi, sym_strobe[gi], e.stb);
                    end else begin
                        check("idle_valid", gi, I_tvalid[gi], 0);
                        check("idle_I", gi, I_tdata[gi], 0);
                        check("idle_Q", gi, Q_tdata[gi], 0);
                        check("idle_strobe", gi, sym_strobe[gi], 0);
                    end
                end
            end
        end
    endgenerate

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]      = 1'b1;
            en[d]       = 1'b0;
            mode[d]     = 1'b0;
            s_tdata[d]  = 8'd0;
            s_tvalid[d] = 1'b0;
            en_mode[d]  = 0;
            en_ph[d]    = 0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        fork
            run(0);
            run(1);
        join
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
